// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the 32-entry, 16-bit CDC ring buffer and its reader.
package cdc_fifo_pkg;

   localparam int unsigned DEPTH = 32;

   typedef logic [$clog2(DEPTH)-1:0] address_t;
   typedef logic [15:0]              data_t;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } skid_state_t;

   // Pointer distance; the address width makes the subtraction wrap mod DEPTH.
   function automatic address_t ptr_delta(input address_t a, input address_t b);
      return a - b;
   endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry output buffer: head drives the stream, skid catches a return while the head stalls.
module stream_skid_buffer
   import cdc_fifo_pkg::*;
#(
   parameter type T = data_t
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_flush,
   input  logic       i_push,
   input  T           i_push_data,
   input  logic       i_pop,
   output T           o_head_data,
   output logic       o_head_valid,
   output logic [1:0] o_occupancy
);

   skid_state_t r_state, w_state_n;
   T            r_head, w_head_n;
   T            r_skid, w_skid_n;

   always_comb begin
      w_state_n = r_state;
      w_head_n  = r_head;
      w_skid_n  = r_skid;
      if (i_flush) begin
         w_state_n = StEmpty;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (i_push) begin
                  w_head_n  = i_push_data;
                  w_state_n = StOne;
               end
            end
            StOne: begin
               if (i_push && i_pop) begin
                  w_head_n = i_push_data;
               end else if (i_push) begin
                  w_skid_n  = i_push_data;
                  w_state_n = StTwo;
               end else if (i_pop) begin
                  w_state_n = StEmpty;
               end
            end
            StTwo: begin
               if (i_pop) begin
                  w_head_n = r_skid;
                  if (i_push) begin
                     w_skid_n = i_push_data;
                  end else begin
                     w_state_n = StOne;
                  end
               end
            end
            default: w_state_n = StEmpty;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StEmpty;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_n;
         r_head  <= w_head_n;
         r_skid  <= w_skid_n;
      end
   end

   assign o_head_data  = r_head;
   assign o_head_valid = (r_state != StEmpty);
   assign o_occupancy  = 2'(r_state);

endmodule

// File: rtl/cdc_stream_reader.sv
// Read-side consumer of the CDC ring buffer: turns producer pointer motion into an in-order
// valid/ready word stream, flushing and counting on producer overrun.
module cdc_stream_reader
   import cdc_fifo_pkg::*;
#(
   parameter int unsigned OVERRUN_LIMIT = 28
) (
   input  logic        read_clk,
   input  logic        read_reset,
   input  logic [4:0]  wr_ptr,
   output logic [4:0]  mem_address,
   input  logic [15:0] mem_data,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overrun,
   input  logic        clear_overrun,
   output logic [7:0]  overrun_count
);

   address_t   r_rd_ptr;
   address_t   r_wr_ptr_q;
   logic [5:0] r_pending;
   logic       r_inflight;
   logic       r_overrun;
   logic [7:0] r_overrun_count;

   address_t   w_delta;
   logic [6:0] w_avail;
   logic       w_overrun_evt;
   logic       w_pop;
   logic       w_push;
   logic       w_issue;
   logic [1:0] w_occ;
   logic [2:0] w_slots;
   data_t      w_head;
   logic       w_head_valid;

   assign w_delta       = ptr_delta(wr_ptr, r_wr_ptr_q);
   assign w_avail       = {1'b0, r_pending} + {2'b00, w_delta};
   assign w_overrun_evt = (w_avail > 7'(OVERRUN_LIMIT));
   assign w_pop         = w_head_valid & out_ready;
   // A slot freed by this cycle's pop can be refilled by the next return: keeps 1 word/cycle.
   assign w_slots       = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue       = (w_avail != 7'd0) && (w_slots < 3'd2) && !w_overrun_evt;
   assign w_push        = r_inflight & ~w_overrun_evt;

   stream_skid_buffer #(
      .T(data_t)
   ) u_skid (
      .i_clk        (read_clk),
      .i_reset      (read_reset),
      .i_flush      (w_overrun_evt),
      .i_push       (w_push),
      .i_push_data  (mem_data),
      .i_pop        (w_pop),
      .o_head_data  (w_head),
      .o_head_valid (w_head_valid),
      .o_occupancy  (w_occ)
   );

   always_ff @(posedge read_clk) begin
      if (read_reset) begin
         // Align to the producer so a free-running writer is neither replayed nor counted.
         r_rd_ptr        <= wr_ptr;
         r_wr_ptr_q      <= wr_ptr;
         r_pending       <= '0;
         r_inflight      <= 1'b0;
         r_overrun       <= 1'b0;
         r_overrun_count <= '0;
      end else begin
         r_wr_ptr_q <= wr_ptr;
         if (w_overrun_evt) begin
            r_rd_ptr   <= wr_ptr;
            r_pending  <= '0;
            r_inflight <= 1'b0;
            r_overrun  <= 1'b1;
            if (r_overrun_count != 8'hFF) begin
               r_overrun_count <= r_overrun_count + 8'd1;
            end
         end else begin
            r_rd_ptr   <= r_rd_ptr + {4'd0, w_issue};
            r_pending  <= w_avail[5:0] - {5'd0, w_issue};
            r_inflight <= w_issue;
            if (clear_overrun) begin
               r_overrun <= 1'b0;
            end
         end
      end
   end

   assign mem_address   = r_rd_ptr;
   assign out_data      = w_head;
   assign out_valid     = w_head_valid;
   assign overrun       = r_overrun;
   assign overrun_count = r_overrun_count;

endmodule

// File: tb/tb_cdc_stream_reader.sv
// Directed bench for cdc_stream_reader: expected words queued at stimulus, checked by a monitor.
module tb_cdc_stream_reader;

   logic        clk = 1'b0;
   logic        read_reset;
   logic [4:0]  wr_ptr;
   logic [4:0]  mem_address;
   logic [15:0] mem_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic        clear_overrun;
   logic [7:0]  overrun_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [4:0]  wp = 5'd0;
   logic [15:0] e;
   logic [5:0]  vec6;
   logic [4:0]  vec5;
   int          held;

   cdc_stream_reader #(
      .OVERRUN_LIMIT(28)
   ) dut (
      .read_clk      (clk),
      .read_reset    (read_reset),
      .wr_ptr        (wr_ptr),
      .mem_address   (mem_address),
      .mem_data      (mem_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   // Buffer memory model: every slot holds 0xA000 + its address, registered read.
   always @(posedge clk) mem_data <= 16'hA000 + {11'd0, mem_address};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic advance(input int n, input bit track);
      logic [4:0] a;
      for (int i = 0; i < n; i++) begin
         a = wp + 5'(i);
         if (track) exp_q.push_back(16'hA000 + {11'd0, a});
      end
      wp     = wp + 5'(n);
      wr_ptr = wp;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         tick(1);
         n++;
      end
      if (exp_q.size() != 0 || out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: drain timeout, %0d words outstanding, required 0", name,
                  exp_q.size());
      end
   endtask

   // Monitor: every handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!read_reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_unexpected: got 0x%0h, required no word", out_data);
         end else begin
            e = exp_q.pop_front();
            check("stream_data", {16'd0, out_data}, {16'd0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      read_reset    = 1'b1;
      wr_ptr        = 5'd0;
      out_ready     = 1'b1;
      clear_overrun = 1'b0;
      tick(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_overrun_count", overrun_count, 0);
      check("rst_mem_address", mem_address, 0);

      read_reset = 1'b0;
      tick(1);
      advance(2, 1'b1);
      drain("first_stream");

      // Reset mid-operation with buffered data and a nonzero producer pointer.
      out_ready = 1'b0;
      advance(3, 1'b1);
      tick(4);
      read_reset = 1'b1;
      wp         = 5'd7;
      wr_ptr     = wp;
      exp_q.delete();
      tick(2);
      read_reset = 1'b0;
      out_ready  = 1'b1;
      tick(3);
      check("reset_drops_data", out_valid, 0);

      // 7 -> 10: valid low for two cycles, then three back-to-back words.
      advance(3, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vec6[i] = out_valid;
      end
      check("latency_valid_pattern", vec6, 6'b011100);
      tick(1);
      drain("latency");

      // Stall with four words available: head held, only two fetches.
      out_ready = 1'b0;
      advance(4, 1'b1);
      repeat (2) @(negedge clk);
      held = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid && out_data == 16'hA00A) held++;
      end
      check("stall_hold", held, 5);
      check("stall_fetch_addr", mem_address, 5'd12);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vec5[i] = out_valid;
      end
      check("release_no_gap", vec5, 5'b01111);
      tick(1);
      drain("stall_release");

      advance(16, 1'b1);
      drain("to_thirty");
      advance(5, 1'b1);
      drain("wrap");

      // Multi-step jump drained under a toggling consumer.
      advance(5, 1'b1);
      for (int i = 0; i < 16; i++) begin
         out_ready = i[0];
         tick(1);
      end
      out_ready = 1'b1;
      drain("jump_toggle");

      for (int i = 0; i < 6; i++) begin
         advance(1, 1'b1);
         tick(1);
      end
      drain("single_steps");

      // Exactly OVERRUN_LIMIT unread entries is tolerated.
      out_ready = 1'b0;
      advance(28, 1'b1);
      tick(6);
      check("limit_no_overrun", overrun, 0);
      check("limit_count", overrun_count, 0);
      out_ready = 1'b1;
      drain("limit_stream");

      // Overrun while stalled with buffered data.
      out_ready = 1'b0;
      advance(3, 1'b1);
      tick(4);
      check("ovr_pre_valid", out_valid, 1);
      advance(29, 1'b0);
      exp_q.delete();
      tick(1);
      check("ovr_flag", overrun, 1);
      check("ovr_count", overrun_count, 1);
      check("ovr_valid_dropped", out_valid, 0);
      check("ovr_rd_ptr", mem_address, wp);
      clear_overrun = 1'b1;
      tick(1);
      clear_overrun = 1'b0;
      check("clear_flag", overrun, 0);
      check("clear_keeps_count", overrun_count, 1);
      out_ready = 1'b1;
      advance(2, 1'b1);
      drain("post_overrun");

      // Set wins over clear in the same cycle.
      clear_overrun = 1'b1;
      advance(29, 1'b0);
      tick(1);
      clear_overrun = 1'b0;
      check("set_wins_flag", overrun, 1);
      check("set_wins_count", overrun_count, 2);

      repeat (300) begin
         advance(29, 1'b0);
         tick(1);
      end
      check("sat_count", overrun_count, 255);
      check("sat_flag", overrun, 1);
      clear_overrun = 1'b1;
      tick(1);
      clear_overrun = 1'b0;
      check("sat_clear_flag", overrun, 0);
      check("sat_count_held", overrun_count, 255);

      advance(3, 1'b1);
      drain("final_stream");
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
